// File: rtl/vga_scan_ctrl.sv
// vga_scan_ctrl: parametrised VGA scan controller.
// Generates H/V timing, issues framebuffer reads (1x or 2x pixel doubling),
// expands RGB332 read data to RGB444 and delay-aligns hs/vs/de/frame_start
// to the colour data. Everything advances only on pix_en_i strobes.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   pix_en_i            pixel strobe
//   scale_i             0 = 1x buffer, 1 = 2x doubled buffer (sampled at frame start)
//   rd_en_o, rd_addr_o  framebuffer read strobe / address
//   rd_data_i           RGB332 read data, valid RD_LAT strobes after issue
//   r_o, g_o, b_o       RGB444 colour
//   hs_o, vs_o, de_o    syncs and display enable, aligned with colour
//   frame_start_o       one-clk pulse when pixel (0,0) reaches the outputs
module vga_scan_ctrl #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0,
  parameter int unsigned RD_LAT   = 1,
  parameter int unsigned ADDR_W   = 19
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pix_en_i,
  input  logic              scale_i,
  output logic              rd_en_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  input  logic [7:0]        rd_data_i,
  output logic [3:0]        r_o,
  output logic [3:0]        g_o,
  output logic [3:0]        b_o,
  output logic              hs_o,
  output logic              vs_o,
  output logic              de_o,
  output logic              frame_start_o
);

  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HC_W     = $clog2(H_TOTAL);
  localparam int unsigned VC_W     = $clog2(V_TOTAL);
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC;
  localparam int unsigned H_HALF   = H_ACTIVE / 2;

  logic [HC_W-1:0]   hcnt_q, hcnt_d;
  logic [VC_W-1:0]   vcnt_q, vcnt_d;
  logic              scale_q, scale_d;
  logic [ADDR_W-1:0] row_base_q, row_base_d;
  logic [ADDR_W-1:0] col_off;
  logic              frame_origin, line_end, frame_end;
  logic              scale_eff, pix_active, hs_act, vs_act;

  // Delay lines for sync/enable/frame markers; bit 0 is loaded at read issue
  logic [RD_LAT-1:0] hs_pipe_q, vs_pipe_q, de_pipe_q, fs_pipe_q;

  logic              rd_en_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [3:0]        r_q, g_q, b_q;
  logic              hs_q, vs_q, de_q, frame_start_q;

  // Scan position decode
  always_comb begin
    frame_origin = (hcnt_q == '0) && (vcnt_q == '0);
    line_end     = (hcnt_q == HC_W'(H_TOTAL - 1));
    frame_end    = (vcnt_q == VC_W'(V_TOTAL - 1));
    // The strobe that samples scale must already use the new value
    scale_eff    = frame_origin ? scale_i : scale_q;
    pix_active   = (hcnt_q < HC_W'(H_ACTIVE)) && (vcnt_q < VC_W'(V_ACTIVE));
    hs_act       = (hcnt_q >= HC_W'(HS_START)) && (hcnt_q < HC_W'(HS_END));
    vs_act       = (vcnt_q >= VC_W'(VS_START)) && (vcnt_q < VC_W'(VS_END));
    col_off      = scale_eff ? ADDR_W'(hcnt_q >> 1) : ADDR_W'(hcnt_q);
  end

  // Next counter / row-base state for the coming strobe
  always_comb begin
    hcnt_d     = hcnt_q + HC_W'(1);
    vcnt_d     = vcnt_q;
    scale_d    = frame_origin ? scale_i : scale_q;
    row_base_d = row_base_q;
    if (line_end) begin
      hcnt_d = '0;
      if (frame_end) begin
        vcnt_d     = '0;
        row_base_d = '0;
      end else begin
        vcnt_d = vcnt_q + VC_W'(1);
        // In 2x mode each buffer row is shown on two consecutive lines
        if (!scale_eff) begin
          row_base_d = row_base_q + ADDR_W'(H_ACTIVE);
        end else if (vcnt_q[0]) begin
          row_base_d = row_base_q + ADDR_W'(H_HALF);
        end
      end
    end
  end

  // Counters, read issue, alignment pipeline and output stage
  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt_q        <= '0;
      vcnt_q        <= '0;
      scale_q       <= 1'b0;
      row_base_q    <= '0;
      hs_pipe_q     <= '0;
      vs_pipe_q     <= '0;
      de_pipe_q     <= '0;
      fs_pipe_q     <= '0;
      rd_en_q       <= 1'b0;
      rd_addr_q     <= '0;
      r_q           <= '0;
      g_q           <= '0;
      b_q           <= '0;
      hs_q          <= ~HS_POL;
      vs_q          <= ~VS_POL;
      de_q          <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      rd_en_q       <= 1'b0;
      frame_start_q <= 1'b0;
      if (pix_en_i) begin
        hcnt_q     <= hcnt_d;
        vcnt_q     <= vcnt_d;
        scale_q    <= scale_d;
        row_base_q <= row_base_d;
        rd_en_q    <= pix_active;
        if (pix_active) begin
          rd_addr_q <= row_base_q + col_off;
        end
        hs_pipe_q <= RD_LAT'({hs_pipe_q, hs_act});
        vs_pipe_q <= RD_LAT'({vs_pipe_q, vs_act});
        de_pipe_q <= RD_LAT'({de_pipe_q, pix_active});
        fs_pipe_q <= RD_LAT'({fs_pipe_q, frame_origin});
        hs_q          <= hs_pipe_q[RD_LAT-1] ? HS_POL : ~HS_POL;
        vs_q          <= vs_pipe_q[RD_LAT-1] ? VS_POL : ~VS_POL;
        de_q          <= de_pipe_q[RD_LAT-1];
        frame_start_q <= fs_pipe_q[RD_LAT-1];
        if (de_pipe_q[RD_LAT-1]) begin
          r_q <= {rd_data_i[7:5], rd_data_i[7]};
          g_q <= {rd_data_i[4:2], rd_data_i[4]};
          b_q <= {rd_data_i[1:0], rd_data_i[1:0]};
        end else begin
          r_q <= '0;
          g_q <= '0;
          b_q <= '0;
        end
      end
    end
  end

  assign rd_en_o       = rd_en_q;
  assign rd_addr_o     = rd_addr_q;
  assign r_o           = r_q;
  assign g_o           = g_q;
  assign b_o           = b_q;
  assign hs_o          = hs_q;
  assign vs_o          = vs_q;
  assign de_o          = de_q;
  assign frame_start_o = frame_start_q;

endmodule
